// File: rtl/exec_issue_ctrl.sv
// Issue sequencer for the multi-cycle execute stage: int/float scoreboard hazard
// check, one-cycle execute start, completion wait with timeout, memory handoff.
module exec_issue_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_rs1_f,
  input  logic        dec_rs2_f,
  input  logic        dec_wr,
  input  logic        dec_fwr,
  output logic        exec_enabled,
  input  logic        exec_completed,
  input  logic        exec_jump_chosen,
  input  logic [31:0] exec_jump_dest,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_f,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREG  = 32;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_HANDOFF} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NREG-1:0]    ipend, ipend_d, fpend, fpend_d;
  logic [REG_W-1:0]   cap_rd;
  logic               cap_wr, cap_fwr;
  logic               hazard, accept, abort, src1_pend, src2_pend;

  // rstn is active-high despite its name
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    abort   = 1'b0;
    unique case (state)
      S_IDLE:    if (accept) state_d = S_EXEC;
      S_EXEC:    state_d = S_WAIT;
      S_WAIT: begin
        if (exec_completed) begin
          state_d = S_HANDOFF;
        end else if (wait_cnt == CNT_LAST) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end
      end
      S_HANDOFF: if (mem_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exec_enabled = (state == S_EXEC);
    mem_valid    = (state == S_HANDOFF);
    busy         = (state != S_IDLE);
    dec_ready    = (state == S_IDLE) & ~hazard & ~flush;
  end

  // Hazard looks only at the registered scoreboard
  always_comb begin
    src1_pend = dec_rs1_f ? fpend[dec_rs1] : ipend[dec_rs1];
    src2_pend = dec_rs2_f ? fpend[dec_rs2] : ipend[dec_rs2];
    hazard    = (dec_use_rs1 & src1_pend) | (dec_use_rs2 & src2_pend) |
                (dec_wr & ipend[dec_rd]) | (dec_fwr & fpend[dec_rd]);
    accept    = dec_valid & dec_ready;
  end

  // Clears first, then sets, so a same-cycle set wins; int r0 is forced clear
  always_comb begin
    ipend_d = ipend;
    fpend_d = fpend;
    if (wb_valid) begin
      if (wb_f) fpend_d[wb_rd] = 1'b0;
      else      ipend_d[wb_rd] = 1'b0;
    end
    if (abort) begin
      if (cap_wr)  ipend_d[cap_rd] = 1'b0;
      if (cap_fwr) fpend_d[cap_rd] = 1'b0;
    end
    if (accept) begin
      if (dec_wr)  ipend_d[dec_rd] = 1'b1;
      if (dec_fwr) fpend_d[dec_rd] = 1'b1;
    end
    ipend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ipend        <= '0;
      fpend        <= '0;
      cap_rd       <= '0;
      cap_wr       <= 1'b0;
      cap_fwr      <= 1'b0;
      wait_cnt     <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      ipend <= ipend_d;
      fpend <= fpend_d;
      if (accept) begin
        cap_rd  <= dec_rd;
        cap_wr  <= dec_wr;
        cap_fwr <= dec_fwr;
      end
      if (state == S_EXEC)      wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      flush <= (state == S_WAIT) & exec_completed & exec_jump_chosen;
      if ((state == S_WAIT) & exec_completed & exec_jump_chosen)
        redirect_pc <= exec_jump_dest;
      if (abort) timeout_err <= 1'b1;
      if (dec_valid & ~dec_ready) stall_cycles <= stall_cycles + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Random-stimulus bench for exec_issue_ctrl: reference scoreboard model in the
// driver, expected outcomes queued per transaction and checked by a monitor.
module tb_exec_issue_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_rs1_f, dec_rs2_f, dec_wr, dec_fwr;
  logic        exec_enabled, exec_completed, exec_jump_chosen;
  logic [31:0] exec_jump_dest;
  logic        mem_valid, mem_ready;
  logic        wb_valid, wb_f;
  logic [4:0]  wb_rd;
  logic        flush, busy, timeout_err;
  logic [31:0] redirect_pc, stall_cycles;

  exec_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rs1_f(dec_rs1_f), .dec_rs2_f(dec_rs2_f), .dec_wr(dec_wr), .dec_fwr(dec_fwr),
    .exec_enabled(exec_enabled), .exec_completed(exec_completed),
    .exec_jump_chosen(exec_jump_chosen), .exec_jump_dest(exec_jump_dest),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_f(wb_f),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        to;
    logic        jmp;
    logic [31:0] dest;
    logic        err;
  } exp_t;

  exp_t        q[$];
  bit          ip[32];
  bit          fp[32];
  bit          err_model;
  bit          skip_mon;
  int unsigned stall_exp;
  int unsigned n_chk;
  int unsigned n_fail;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend(input bit f, input logic [4:0] r);
    return f ? fp[r] : ip[r];
  endfunction

  function automatic bit hz();
    return (dec_use_rs1 && pend(dec_rs1_f, dec_rs1)) || (dec_use_rs2 && pend(dec_rs2_f, dec_rs2)) ||
           (dec_wr && ip[dec_rd]) || (dec_fwr && fp[dec_rd]);
  endfunction

  task automatic rand_instr();
    dec_rs1     = 5'($urandom_range(0, 7));
    dec_rs2     = 5'($urandom_range(0, 7));
    dec_rd      = 5'($urandom_range(0, 7));
    dec_use_rs1 = 1'($urandom_range(0, 1));
    dec_use_rs2 = 1'($urandom_range(0, 1));
    dec_rs1_f   = 1'($urandom_range(0, 1));
    dec_rs2_f   = 1'($urandom_range(0, 1));
    dec_wr      = 1'($urandom_range(0, 1));
    dec_fwr     = !dec_wr && ($urandom_range(0, 2) == 0);
  endtask

  // Writeback: mostly retires a pending register, sometimes a random one
  task automatic rand_wb(input bit force_pend);
    int c[$];
    int k;
    wb_valid = 1'b0;
    for (int i = 0; i < 64; i++) if (i < 32 ? ip[i] : fp[i-32]) c.push_back(i);
    if (force_pend || $urandom_range(0, 9) < 4) begin
      wb_valid = 1'b1;
      if (c.size() > 0 && (force_pend || $urandom_range(0, 9) < 7)) begin
        k     = c[$urandom_range(0, c.size() - 1)];
        wb_f  = (k >= 32);
        wb_rd = 5'(k % 32);
      end else begin
        wb_f  = 1'($urandom_range(0, 1));
        wb_rd = 5'($urandom_range(0, 7));
      end
    end
  endtask

  // Reference scoreboard update at a clock edge: a set beats a same-cycle clear
  task automatic edge_update(input bit acc);
    if (wb_valid) begin
      if (wb_f) fp[wb_rd] = 1'b0;
      else if (wb_rd != 5'd0) ip[wb_rd] = 1'b0;
    end
    if (acc) begin
      if (dec_wr && dec_rd != 5'd0) ip[dec_rd] = 1'b1;
      if (dec_fwr) fp[dec_rd] = 1'b1;
    end
  endtask

  task automatic busy_cycle(input logic exp_en, input logic exp_mv);
    @(negedge clk);
    chk1("exec_enabled", exec_enabled, exp_en);
    chk1("mem_valid", mem_valid, exp_mv);
    chk1("busy", busy, 1'b1);
    chk1("dec_ready_busy", dec_ready, 1'b0);
    if (dec_valid) stall_exp++;
    @(posedge clk);
    edge_update(1'b0);
    #1;
    rand_wb(1'b0);
    rand_instr();
    dec_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input bit hold10);
    bit          acc;
    bit          exp_r;
    bit          wr, fwr, jmp, hs;
    logic [4:0]  rd;
    logic [31:0] dst;
    int          tries, d, n;
    acc = 1'b0; tries = 0; wr = 1'b0; fwr = 1'b0; rd = '0;
    rand_instr();
    dec_valid = 1'b1;
    while (!acc) begin
      exec_completed   = ($urandom_range(0, 3) == 0);
      exec_jump_chosen = 1'b1;
      @(negedge clk);
      chk32("stall_cycles", stall_cycles, stall_exp);
      chk1("busy_idle", busy, 1'b0);
      exp_r = !hz();
      chk1("dec_ready", dec_ready, exp_r);
      if (!exp_r) stall_exp++;
      acc = exp_r;
      @(posedge clk);
      edge_update(acc);
      #1;
      if (acc) begin rd = dec_rd; wr = dec_wr; fwr = dec_fwr; end
      tries++;
      rand_wb(tries > 20);
    end
    exec_completed = 1'b0;
    dec_valid = 1'($urandom_range(0, 1));
    d   = $urandom_range(0, TO + 1);
    jmp = 1'($urandom_range(0, 1));
    dst = $urandom();
    q.push_back('{to: (d >= TO), jmp: jmp, dest: dst, err: err_model || (d >= TO)});
    busy_cycle(1'b1, 1'b0);
    for (int k = 0; k < TO; k++) begin
      exec_completed   = (k == d);
      exec_jump_chosen = (k == d) ? jmp : 1'($urandom_range(0, 1));
      exec_jump_dest   = (k == d) ? dst : $urandom();
      busy_cycle(1'b0, 1'b0);
      if (k == d) break;
    end
    exec_completed = 1'b0;
    if (d >= TO) begin
      err_model = 1'b1;
      if (wr && rd != 5'd0) ip[rd] = 1'b0;
      if (fwr) fp[rd] = 1'b0;
      return;
    end
    hs = 1'b0; n = 0;
    while (!hs) begin
      mem_ready        = (hold10 && n < 10) ? 1'b0 : ((n >= 12) ? 1'b1 : ($urandom_range(0, 2) == 0));
      exec_completed   = ($urandom_range(0, 3) == 0);
      exec_jump_chosen = 1'b1;
      exec_jump_dest   = $urandom();
      hs = mem_ready;
      busy_cycle(1'b0, 1'b1);
      n++;
    end
    mem_ready      = 1'b0;
    exec_completed = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_exec_enabled"}, exec_enabled, 1'b0);
    chk1({tag, "_mem_valid"}, mem_valid, 1'b0);
    chk1({tag, "_flush"}, flush, 1'b0);
    chk32({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    chk32({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic reset_test(input bit in_ho);
    dec_valid = 1'b0;
    @(posedge clk);
    edge_update(1'b0);
    #1;
    skip_mon = 1'b1;
    wb_valid = 1'b0; exec_completed = 1'b0; mem_ready = 1'b0;
    dec_valid = 1'b1; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_wr = 1'b0; dec_fwr = 1'b0;
    @(negedge clk);
    chk1("rst_seq_ready", dec_ready, 1'b1);
    @(posedge clk); #1; dec_valid = 1'b0;
    @(posedge clk); #1;
    if (in_ho) begin
      exec_completed = 1'b1; exec_jump_chosen = 1'b1; exec_jump_dest = 32'h0000_0100;
      @(posedge clk); #1;
      exec_completed = 1'b0;
      chk1("pre_rst_mem_valid", mem_valid, 1'b1);
      chk1("pre_rst_flush", flush, 1'b1);
    end
    chk1("pre_rst_busy", busy, 1'b1);
    #2 rstn = 1'b1;
    #1;
    check_reset_vals(in_ho ? "rst_handoff" : "rst_wait");
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 32; i++) begin ip[i] = 1'b0; fp[i] = 1'b0; end
    err_model = 1'b0; stall_exp = 0;
    @(posedge clk); #1;
    exec_completed = 1'b1; exec_jump_chosen = 1'b1;
    @(posedge clk); #1;
    exec_completed = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1("post_rst_mem_valid", mem_valid, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
      chk1("post_rst_flush", flush, 1'b0);
    end
    @(posedge clk); #1;
    skip_mon = 1'b0;
  endtask

  // Monitor: compares DUT handoffs/aborts against the queued expectations
  initial begin
    bit   pb, pm, phs;
    exp_t e;
    pb = 1'b0; pm = 1'b0; phs = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn || skip_mon) begin
        pb = 1'b0; pm = 1'b0; phs = 1'b0;
      end else begin
        if (mem_valid && !pm) begin
          chk32("handoff_expected", 32'(q.size()), 32'd1);
          if (q.size() > 0) begin
            chk1("flush", flush, q[0].jmp);
            if (q[0].jmp) chk32("redirect_pc", redirect_pc, q[0].dest);
          end
        end else begin
          chk1("flush_stray", flush, 1'b0);
        end
        if (pb && !busy) begin
          chk32("txn_expected", 32'(q.size()), 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk1("handoff_not_timeout", phs, !e.to);
            chk1("timeout_err", timeout_err, e.err);
          end
        end
        pb  = busy;
        pm  = mem_valid;
        phs = mem_valid && mem_ready;
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; stall_exp = 0; err_model = 1'b0; skip_mon = 1'b0;
    for (int i = 0; i < 32; i++) begin ip[i] = 1'b0; fp[i] = 1'b0; end
    rstn = 1'b1;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rs1_f = 1'b0; dec_rs2_f = 1'b0;
    dec_wr = 1'b0; dec_fwr = 1'b0;
    exec_completed = 1'b0; exec_jump_chosen = 1'b0; exec_jump_dest = '0;
    mem_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_f = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < 120; t++) run_txn(t % 5 == 0);
    reset_test(1'b0);
    reset_test(1'b1);
    for (int t = 0; t < 60; t++) run_txn(t % 7 == 0);
    dec_valid = 1'b0;
    repeat (2) begin @(posedge clk); edge_update(1'b0); #1; wb_valid = 1'b0; end
    chk32("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
